// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared widths, entry layout and the empty-queue bubble
package if_id_queue_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] ZERO_WORD = '0;
    typedef struct packed {
        logic                    first;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
    } entry_t;
    localparam entry_t BUBBLE = '0;
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side and decode-side handshake bundle of the IF/ID queue
interface if_id_queue_if
    import if_id_queue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    localparam int CNTW = $clog2(DEPTH) + 1
);
    logic            flush;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_inst;
    logic            if_first;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;
    logic            id_first;
    logic [CNTW-1:0] count;
    modport master (
        output flush, if_valid, if_pc, if_inst, if_first, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, id_first, count
    );
    modport slave (
        input  flush, if_valid, if_pc, if_inst, if_first, id_ready,
        output if_ready, id_valid, id_pc, id_inst, id_first, count
    );
endinterface

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: entry storage with one synchronous write port and one async read port
module if_id_queue_mem #(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    // storage is never reset; stale entries are hidden by the count-based output mask
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry IF->ID decoupling FIFO with valid/ready on both sides and flush
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    localparam int CNTW = $clog2(DEPTH) + 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int W    = 2 * XLEN + 1
) (
    input logic         clk,
    input logic         rst,
    if_id_queue_if.slave q
);
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CNTW-1:0] cnt;
    logic [W-1:0]    head;
    logic            enq, deq;

    assign q.if_ready = cnt != CNTW'(DEPTH);
    assign q.id_valid = cnt != '0;
    assign q.count    = cnt;
    assign enq = q.if_valid & q.if_ready & ~q.flush;
    assign deq = q.id_valid & q.id_ready & ~q.flush;
    assign {q.id_first, q.id_pc, q.id_inst} = q.id_valid ? head : '0;

    if_id_queue_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (enq),
        .waddr(wr_ptr),
        .wdata({q.if_first, q.if_pc, q.if_inst}),
        .raddr(rd_ptr),
        .rdata(head)
    );

    // pointers and occupancy; flush behaves exactly like reset
    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            cnt <= (enq && !deq) ? cnt + CNTW'(1) : (deq && !enq) ? cnt - CNTW'(1) : cnt;
        end
    end

    // overflow and underflow cannot happen because enq/deq are gated by count
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq && cnt == CNTW'(DEPTH)));
            assert (!(deq && cnt == '0));
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue (DEPTH = 4)
module tb_if_id_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    if_id_queue_if #(.XLEN(32), .DEPTH(4)) q ();
    if_id_queue #(.XLEN(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .q(q));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic f);
        q.if_valid = v;
        q.if_pc    = pc;
        q.if_inst  = pc ^ 32'hDEAD_0000;
        q.if_first = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h99, 1'b1);
        q.id_ready = 1'b1;
        step();
        step();
        checks++; if (q.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", q.count); end
        checks++; if (q.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b exp 0", q.id_valid); end
        checks++; if (q.if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b exp 1", q.if_ready); end
        checks++; if ({q.id_first, q.id_pc, q.id_inst} !== 65'd0) begin errors++; $display("FAIL reset_bubble got %0h/%0h/%0b exp 0", q.id_pc, q.id_inst, q.id_first); end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        q.id_ready = 1'b0;
        step();
    endtask

    task automatic test_fill();
        q.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0);
            step();
            checks++; if (q.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, q.count, i + 1); end
            checks++; if (q.id_pc !== 32'h0) begin errors++; $display("FAIL fill_head[%0d] got %0h exp 0", i, q.id_pc); end
        end
        checks++; if (q.if_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b exp 0", q.if_ready); end
        drive(1'b1, 32'h10, 1'b0);
        step();
        checks++; if (q.count !== 3'd4) begin errors++; $display("FAIL fill_held_count got %0d exp 4", q.count); end
        checks++; if (q.id_pc !== 32'h0 || q.id_inst !== 32'hDEAD_0000) begin errors++; $display("FAIL fill_held_head got %0h/%0h exp 0/dead0000", q.id_pc, q.id_inst); end
    endtask

    task automatic test_drain_wrap();
        logic        v_tab [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic [31:0] p_tab [8] = '{32'h10, 32'h14, 32'h18, 32'h1C, 0, 0, 0, 0};
        logic [31:0] h_tab [8] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h0};
        int          c_tab [8] = '{3, 3, 3, 3, 3, 2, 1, 0};
        q.id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            drive(v_tab[i], p_tab[i], 1'b0);
            checks++; if (q.count !== 3'(c_tab[i])) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, q.count, c_tab[i]); end
            checks++; if (q.id_pc !== h_tab[i]) begin errors++; $display("FAIL drain_pc[%0d] got %0h exp %0h", i, q.id_pc, h_tab[i]); end
            if (c_tab[i] != 0) begin
                checks++; if (q.id_inst !== (h_tab[i] ^ 32'hDEAD_0000)) begin errors++; $display("FAIL drain_inst[%0d] got %0h exp %0h", i, q.id_inst, h_tab[i] ^ 32'hDEAD_0000); end
            end
        end
        checks++; if (q.id_inst !== 32'h0 || q.id_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0h/%0b exp 0/0", q.id_inst, q.id_valid); end
        q.id_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        q.id_ready = 1'b0;
        drive(1'b1, 32'h20, 1'b0);
        step();
        drive(1'b1, 32'h24, 1'b0);
        step();
        q.id_ready = 1'b1;
        drive(1'b1, 32'h28, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (q.count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", q.count); end
        checks++; if (q.id_pc !== 32'h24) begin errors++; $display("FAIL b2b_head got %0h exp 24", q.id_pc); end
        step();
        checks++; if (q.id_pc !== 32'h28 || q.count !== 3'd1) begin errors++; $display("FAIL b2b_next got %0h/%0d exp 28/1", q.id_pc, q.count); end
        step();
        checks++; if (q.count !== 3'd0) begin errors++; $display("FAIL b2b_drained got %0d exp 0", q.count); end
        q.id_ready = 1'b0;
    endtask

    task automatic test_flush();
        q.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h30 + 4 * i), 1'b0);
            step();
        end
        checks++; if (q.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", q.count); end
        q.flush = 1'b1;
        q.id_ready = 1'b1;
        drive(1'b1, 32'h40, 1'b0);
        step();
        q.flush = 1'b0;
        q.id_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (q.count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", q.count); end
        checks++; if (q.id_inst !== 32'h0 || q.id_pc !== 32'h0 || q.id_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble got %0h/%0h/%0b exp 0/0/0", q.id_pc, q.id_inst, q.id_valid); end
        checks++; if (q.if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", q.if_ready); end
        drive(1'b1, 32'h80, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (q.id_pc !== 32'h80 || q.id_first !== 1'b1 || q.count !== 3'd1) begin errors++; $display("FAIL flush_refetch got %0h/%0b/%0d exp 80/1/1", q.id_pc, q.id_first, q.count); end
        q.id_ready = 1'b1;
        step();
        checks++; if (q.id_first !== 1'b0 || q.count !== 3'd0) begin errors++; $display("FAIL flush_refetch_drain got %0b/%0d exp 0/0", q.id_first, q.count); end
        q.id_ready = 1'b0;
    endtask

    task automatic test_full_boundary();
        q.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(32'h50 + 4 * i), 1'b0);
            step();
        end
        q.id_ready = 1'b1;
        drive(1'b1, 32'h60, 1'b0);
        checks++; if (q.if_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pre got %0b exp 0", q.if_ready); end
        step();
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (q.count !== 3'd3) begin errors++; $display("FAIL full_count got %0d exp 3", q.count); end
        checks++; if (q.if_ready !== 1'b1) begin errors++; $display("FAIL full_ready_post got %0b exp 1", q.if_ready); end
        checks++; if (q.id_pc !== 32'h54) begin errors++; $display("FAIL full_head got %0h exp 54", q.id_pc); end
        step();
        step();
        step();
        checks++; if (q.count !== 3'd0 || q.id_valid !== 1'b0) begin errors++; $display("FAIL full_drain got %0d/%0b exp 0/0 (0x60 must not be queued)", q.count, q.id_valid); end
        q.id_ready = 1'b0;
    endtask

    task automatic test_midburst_reset();
        q.id_ready = 1'b0;
        drive(1'b1, 32'h90, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (q.count !== 3'd0 || q.id_valid !== 1'b0 || q.id_first !== 1'b0 || q.id_pc !== 32'h0) begin errors++; $display("FAIL midreset got %0d/%0b/%0b/%0h exp 0/0/0/0", q.count, q.id_valid, q.id_first, q.id_pc); end
    endtask

    initial begin
        q.flush = 1'b0;
        q.id_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        test_reset();
        test_fill();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
        test_full_boundary();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
